// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM state encoding and the default fetch-starvation limit.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_I = 3'd1,
    ACC_D = 3'd2,
    RSP_I = 3'd3,
    RSP_D = 3'd4
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 3;

  // Width needed to hold a saturating counter that counts 0..max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Priority decision between the fetch and data ports: data normally wins,
// but a fetch that has been passed over STARVE_MAX times takes the slot.
module arb_pick #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             pick_i,
  output logic             pick_d
);

  logic starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
  assign pick_i  = if_req & (~d_req | starved);
  assign pick_d  = d_req & ~pick_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported synchronous RAM.
// Each access takes an address cycle (ACC_x) and a response cycle (RSP_x).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  starve_reg, starve_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

  logic can_arb;
  logic pick_i;
  logic pick_d;

  // Arbitration happens whenever the RAM port is free for the next cycle
  assign can_arb = (state_reg == IDLE) || (state_reg == RSP_I) || (state_reg == RSP_D);

  arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .starve_cnt(starve_reg),
    .pick_i    (pick_i),
    .pick_d    (pick_d)
  );

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    we_next       = we_reg;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    if_gnt        = 1'b0;
    if_valid      = 1'b0;
    d_gnt         = 1'b0;
    d_valid       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    if_rdata      = if_rdata_reg;
    d_rdata       = d_rdata_reg;

    case (state_reg)
      ACC_I: begin
        state_next = RSP_I;
        if_gnt     = 1'b1;
        mem_read   = 1'b1;
      end
      ACC_D: begin
        state_next = RSP_D;
        d_gnt      = 1'b1;
        mem_read   = ~we_reg;
        mem_write  = we_reg;
      end
      RSP_I: begin
        if_valid      = 1'b1;
        if_rdata      = mem_rdata;
        if_rdata_next = mem_rdata;
      end
      RSP_D: begin
        d_valid      = 1'b1;
        d_rdata      = we_reg ? '0 : mem_rdata;
        d_rdata_next = we_reg ? '0 : mem_rdata;
      end
      default: ;
    endcase

    // Response cycles double as arbitration cycles for back-to-back accesses
    if (can_arb) begin
      if (pick_d) begin
        state_next = ACC_D;
        addr_next  = d_addr;
        wdata_next = d_wdata;
        we_next    = d_we;
      end else if (pick_i) begin
        state_next = ACC_I;
        addr_next  = if_addr;
        we_next    = 1'b0;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if (!if_req || (can_arb && pick_i)) begin
      starve_next = '0;
    end else if (can_arb && pick_d && (starve_reg != CNT_W'(STARVE_MAX))) begin
      starve_next = starve_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= IDLE;
      starve_reg   <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      starve_reg   <= starve_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      we_reg       <= we_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level
// model that tracks the current access slot and the fetch starvation count.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          clr;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;  // 0 directed, 1 random, 2 both requests held forever

  // Model: phase counts remaining cycles of the current access (2 = address
  // cycle, 1 = response cycle, 0 = no access); kind 1 = fetch, 2 = data.
  int            m_phase  = 0;
  int            m_kind   = 0;
  int            m_starve = 0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic          m_we     = 1'b0;
  logic [DW-1:0] m_if_hold = '0;
  logic [DW-1:0] m_d_hold  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called just after a rising edge, with the inputs that edge sampled.
  task automatic model_step();
    bit win_i;
    bit win_d;
    win_i = 1'b0;
    win_d = 1'b0;
    if (clr) begin
      m_phase = 0; m_kind = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_if_hold = '0; m_d_hold = '0;
    end else begin
      if (m_phase == 1) begin
        if (m_kind == 1) m_if_hold = mem_rdata;
        else             m_d_hold  = m_we ? '0 : mem_rdata;
      end
      if (m_phase != 2) begin
        win_i = if_req && (!d_req || m_starve == SMAX);
        win_d = d_req && !win_i;
      end
      if (!if_req || win_i)               m_starve = 0;
      else if (win_d && m_starve < SMAX)  m_starve = m_starve + 1;
      if (m_phase == 2) begin
        m_phase = 1;
      end else if (win_d) begin
        m_phase = 2; m_kind = 2;
        m_addr = d_addr; m_wdata = d_wdata; m_we = d_we;
      end else if (win_i) begin
        m_phase = 2; m_kind = 1;
        m_addr = if_addr; m_we = 1'b0;
      end else begin
        m_phase = 0; m_kind = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit acc_i, acc_d, rsp_i, rsp_d;
    acc_i = (m_phase == 2 && m_kind == 1);
    acc_d = (m_phase == 2 && m_kind == 2);
    rsp_i = (m_phase == 1 && m_kind == 1);
    rsp_d = (m_phase == 1 && m_kind == 2);
    check("if_gnt",    if_gnt,    acc_i);
    check("d_gnt",     d_gnt,     acc_d);
    check("if_valid",  if_valid,  rsp_i);
    check("d_valid",   d_valid,   rsp_d);
    check("mem_read",  mem_read,  acc_i || (acc_d && !m_we));
    check("mem_write", mem_write, acc_d && m_we);
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("if_rdata",  if_rdata,  rsp_i ? mem_rdata : m_if_hold);
    check("d_rdata",   d_rdata,   rsp_d ? (m_we ? '0 : mem_rdata) : m_d_hold);
    if (rsp_i) $display("txn cycle %0d: fetch addr=%h rdata=%h", cyc, m_addr, if_rdata);
    if (rsp_d) $display("txn cycle %0d: %s addr=%h wdata=%h rdata=%h", cyc,
                        m_we ? "store" : "load", m_addr, m_wdata, d_rdata);
  endtask

  task automatic cycle();
    bit prev_i, prev_d;
    @(posedge clk);
    prev_i = (m_phase == 2 && m_kind == 1);
    prev_d = (m_phase == 2 && m_kind == 2);
    model_step();
    #1;
    if (mode != 2) begin
      if (prev_i) if_req = 1'b0;
      if (prev_d) d_req  = 1'b0;
    end
    if (mode == 1) begin
      clr = ($urandom_range(0, 63) == 0);
      if (!prev_i && !if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (!prev_d && !d_req && $urandom_range(0, 1) == 0) begin
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_rdata = $urandom;
    end
    @(negedge clk);
    check_outputs();
    cyc++;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    cycle();
    cycle();
    clr = 1'b0;
  endtask

  int nd, ni, nany;
  int grant_seq[$];

  initial begin
    clr = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    mode = 0;
    do_reset();

    // Uncontended fetch
    mem_rdata = 32'h00500093; if_addr = 32'h100; if_req = 1'b1;
    cycle();
    check("fetch gnt",  if_gnt,   1'b1);
    check("fetch addr", mem_addr, 32'h100);
    check("fetch read", mem_read, 1'b1);
    cycle();
    check("fetch valid", if_valid, 1'b1);
    check("fetch data",  if_rdata, 32'h00500093);
    cycle();

    // Uncontended store
    d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_we = 1'b1; d_req = 1'b1;
    cycle();
    check("store gnt",   d_gnt,     1'b1);
    check("store write", mem_write, 1'b1);
    check("store wdata", mem_wdata, 32'hDEADBEEF);
    cycle();
    check("store valid", d_valid, 1'b1);
    check("store rdata", d_rdata, 32'h0);
    cycle();

    // Simultaneous single requests: data then fetch, back to back
    d_we = 1'b0; d_addr = 32'h44; if_addr = 32'h200; mem_rdata = 32'h1234;
    d_req = 1'b1; if_req = 1'b1;
    cycle();
    check("both d_gnt first",  d_gnt,  1'b1);
    check("both if_gnt later", if_gnt, 1'b0);
    cycle();
    check("both d_valid", d_valid, 1'b1);
    cycle();
    check("both if_gnt", if_gnt, 1'b1);
    cycle();
    check("both if_valid", if_valid, 1'b1);
    cycle();

    // Reset during a data access cycle aborts it
    d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    cycle();
    check("abort d_gnt", d_gnt, 1'b1);
    clr = 1'b1;
    cycle();
    check("abort d_valid", d_valid, 1'b0);
    check("abort strobes", {mem_read, mem_write, d_gnt, if_gnt}, 4'b0);
    clr = 1'b0;
    cycle();
    check("abort no late valid", d_valid, 1'b0);

    // Idle for 10 cycles
    nany = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      nany += int'(mem_read) + int'(mem_write) + int'(if_gnt) + int'(d_gnt)
            + int'(if_valid) + int'(d_valid);
    end
    check("idle activity", nany, 0);

    // Both held continuously: D,D,D,I repeating, one grant every 2 cycles
    do_reset();
    mode = 2;
    if_addr = 32'h300; d_addr = 32'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    nd = 0; ni = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (d_gnt)  begin nd++; grant_seq.push_back(2); end
      if (if_gnt) begin ni++; grant_seq.push_back(1); end
    end
    check("held d grants", nd, 15);
    check("held i grants", ni, 5);
    check("held 4th grant is fetch", grant_seq.size() > 3 ? grant_seq[3] : 0, 1);
    check("held 5th grant is data",  grant_seq.size() > 4 ? grant_seq[4] : 0, 2);
    if_req = 1'b0; d_req = 1'b0;
    mode = 0;
    cycle();
    cycle();

    // Random traffic with occasional resets
    mode = 1;
    for (int i = 0; i < 3000; i++) cycle();
    mode = 0;
    clr = 1'b0; if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
